// File: rtl/vid_pkg.sv
// Shared types and constants for the AXI4-Stream video sink: FSM states,
// default geometry and the TREADY throttle LFSR definition.
package vid_pkg;

  typedef enum logic {
    WAIT_SOF = 1'b0,
    RECEIVE  = 1'b1
  } vid_state_e;

  localparam int H_PIXELS_DEF = 1280;
  localparam int V_LINES_DEF  = 720;
  localparam int DATA_W_DEF   = 24;

  // x^8 + x^6 + x^5 + x^4 + 1, Fibonacci form shifting towards the MSB
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/axis_vid_ready_gen.sv
// Registered TREADY source: constant ready, or a pseudo-random throttle
// taken from bit 0 of a free-running 8-bit LFSR.
module axis_vid_ready_gen
  import vid_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic throttle,
  output logic tready
);

  logic [7:0] lfsr_q, lfsr_d;
  logic       tready_q, tready_d;

  always_comb begin
    lfsr_d   = lfsr_next(lfsr_q);
    tready_d = throttle ? lfsr_d[0] : 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q   <= LFSR_SEED;
      tready_q <= 1'b0;
    end else begin
      lfsr_q   <= lfsr_d;
      tready_q <= tready_d;
    end
  end

  assign tready = tready_q;

endmodule

// File: rtl/axis_vid_sink.sv
// AXI4-Stream video sink: tracks pixel/line position, checks SOF/EOL framing,
// accumulates a per-frame checksum and reports frame count and sticky errors.
module axis_vid_sink
  import vid_pkg::*;
#(
  parameter int H_PIXELS = H_PIXELS_DEF,
  parameter int V_LINES  = V_LINES_DEF,
  parameter int DATA_W   = DATA_W_DEF
) (
  input  logic              AXIS_VID_ACLK,
  input  logic              AXIS_VID_ARESETN,
  input  logic [DATA_W-1:0] AXIS_VID_TDATA,
  input  logic              AXIS_VID_TLAST,
  input  logic              AXIS_VID_TUSER,
  input  logic              AXIS_VID_TVALID,
  output logic              AXIS_VID_TREADY,
  input  logic              THROTTLE,
  input  logic              CLEAR,
  output logic              FRAME_DONE,
  output logic [15:0]       FRAME_COUNT,
  output logic [31:0]       FRAME_SUM,
  output logic              ERR_SOF,
  output logic              ERR_EOL_EARLY,
  output logic              ERR_EOL_LATE
);

  localparam int XW = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1;
  localparam int YW = (V_LINES > 1) ? $clog2(V_LINES) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(H_PIXELS - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_LINES - 1);

  vid_state_e    state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [31:0]   sum_q, sum_d;
  logic          frame_done_q, frame_done_d;
  logic [15:0]   frame_count_q, frame_count_d;
  logic [31:0]   frame_sum_q, frame_sum_d;
  logic          err_sof_q, err_sof_d;
  logic          err_eol_early_q, err_eol_early_d;
  logic          err_eol_late_q, err_eol_late_d;

  logic          tready;
  logic          accept;
  logic [31:0]   pix;
  logic [31:0]   sum_next;
  logic          eol;

  axis_vid_ready_gen u_ready_gen (
    .clk      (AXIS_VID_ACLK),
    .rst_n    (AXIS_VID_ARESETN),
    .throttle (THROTTLE),
    .tready   (tready)
  );

  assign accept   = AXIS_VID_TVALID & tready;
  assign pix      = 32'(AXIS_VID_TDATA);
  assign sum_next = sum_q + pix;
  assign eol      = AXIS_VID_TLAST | (x_q == X_LAST);

  always_comb begin
    state_d         = state_q;
    x_d             = x_q;
    y_d             = y_q;
    sum_d           = sum_q;
    frame_done_d    = 1'b0;
    frame_count_d   = frame_count_q;
    frame_sum_d     = frame_sum_q;
    err_sof_d       = err_sof_q;
    err_eol_early_d = err_eol_early_q;
    err_eol_late_d  = err_eol_late_q;

    if (accept) begin
      // A TUSER beat always (re)starts a frame as pixel 0, aborting any partial frame
      if (AXIS_VID_TUSER) begin
        if (state_q == RECEIVE) err_sof_d = 1'b1;
        x_d     = AXIS_VID_TLAST ? '0 : XW'(1);
        y_d     = '0;
        sum_d   = pix;
        state_d = RECEIVE;
      end else if (state_q == RECEIVE) begin
        sum_d = sum_next;
        if (AXIS_VID_TLAST && (x_q != X_LAST)) err_eol_early_d = 1'b1;
        if (!AXIS_VID_TLAST && (x_q == X_LAST)) err_eol_late_d = 1'b1;
        if (eol) begin
          x_d = '0;
          if (y_q == Y_LAST) begin
            y_d           = '0;
            frame_done_d  = 1'b1;
            frame_count_d = frame_count_q + 16'd1;
            frame_sum_d   = sum_next;
            state_d       = WAIT_SOF;
          end else begin
            y_d = y_q + YW'(1);
          end
        end else begin
          x_d = x_q + XW'(1);
        end
      end
    end

    if (CLEAR) begin
      frame_count_d   = '0;
      err_sof_d       = 1'b0;
      err_eol_early_d = 1'b0;
      err_eol_late_d  = 1'b0;
    end
  end

  always_ff @(posedge AXIS_VID_ACLK or negedge AXIS_VID_ARESETN) begin
    if (!AXIS_VID_ARESETN) begin
      state_q         <= WAIT_SOF;
      x_q             <= '0;
      y_q             <= '0;
      sum_q           <= '0;
      frame_done_q    <= 1'b0;
      frame_count_q   <= '0;
      frame_sum_q     <= '0;
      err_sof_q       <= 1'b0;
      err_eol_early_q <= 1'b0;
      err_eol_late_q  <= 1'b0;
    end else begin
      state_q         <= state_d;
      x_q             <= x_d;
      y_q             <= y_d;
      sum_q           <= sum_d;
      frame_done_q    <= frame_done_d;
      frame_count_q   <= frame_count_d;
      frame_sum_q     <= frame_sum_d;
      err_sof_q       <= err_sof_d;
      err_eol_early_q <= err_eol_early_d;
      err_eol_late_q  <= err_eol_late_d;
    end
  end

  assign AXIS_VID_TREADY = tready;
  assign FRAME_DONE      = frame_done_q;
  assign FRAME_COUNT     = frame_count_q;
  assign FRAME_SUM       = frame_sum_q;
  assign ERR_SOF         = err_sof_q;
  assign ERR_EOL_EARLY   = err_eol_early_q;
  assign ERR_EOL_LATE    = err_eol_late_q;

endmodule

// File: tb/tb_axis_vid_sink.sv
// Scoreboard bench for axis_vid_sink with an 8x4 frame: expected frame
// checksum/count entries are queued by the stimulus and popped on FRAME_DONE.
module tb_axis_vid_sink;

  localparam int H  = 8;
  localparam int V  = 4;
  localparam int DW = 24;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] tdata;
  logic          tlast, tuser, tvalid;
  logic          tready;
  logic          throttle, clear;
  logic          done;
  logic [15:0]   cnt;
  logic [31:0]   fsum;
  logic          e_sof, e_early, e_late;

  typedef struct {
    logic [31:0] sum;
    logic [15:0] cnt;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   stalls = 0;
  int   exp_count = 0;

  axis_vid_sink #(.H_PIXELS(H), .V_LINES(V), .DATA_W(DW)) dut (
    .AXIS_VID_ACLK    (clk),
    .AXIS_VID_ARESETN (rst_n),
    .AXIS_VID_TDATA   (tdata),
    .AXIS_VID_TLAST   (tlast),
    .AXIS_VID_TUSER   (tuser),
    .AXIS_VID_TVALID  (tvalid),
    .AXIS_VID_TREADY  (tready),
    .THROTTLE         (throttle),
    .CLEAR            (clear),
    .FRAME_DONE       (done),
    .FRAME_COUNT      (cnt),
    .FRAME_SUM        (fsum),
    .ERR_SOF          (e_sof),
    .ERR_EOL_EARLY    (e_early),
    .ERR_EOL_LATE     (e_late)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_err(input string nm, input logic s, input logic e, input logic l);
    chk({nm, "_err_sof"}, {31'd0, e_sof}, {31'd0, s});
    chk({nm, "_err_eol_early"}, {31'd0, e_early}, {31'd0, e});
    chk({nm, "_err_eol_late"}, {31'd0, e_late}, {31'd0, l});
  endtask

  task automatic push_exp(input logic [31:0] s);
    exp_t e;
    exp_count++;
    e.sum = s;
    e.cnt = 16'(exp_count);
    q.push_back(e);
  endtask

  // Present one beat with TVALID held until TREADY takes it
  task automatic beat(input logic [DW-1:0] d, input logic u, input logic l);
    int w;
    tvalid = 1'b1;
    tdata  = d;
    tuser  = u;
    tlast  = l;
    w = 0;
    @(negedge clk);
    while (!tready && w < 200) begin
      w++;
      stalls++;
      @(negedge clk);
    end
    if (!tready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL beat_timeout: got tready=0 for %0d cycles, want 1", w);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    tvalid = 1'b0;
    tuser  = 1'b0;
    tlast  = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Pixels 0..n_px-1 with data = x; TLAST on the final pixel unless no_last
  task automatic send_line(input int n_px, input logic sof, input logic no_last);
    for (int x = 0; x < n_px; x++)
      beat(DW'(x), sof && (x == 0), (x == n_px - 1) && !no_last);
  endtask

  task automatic send_frame();
    for (int y = 0; y < V; y++) send_line(H, y == 0, 1'b0);
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_tready"}, {31'd0, tready}, 32'd0);
    chk({nm, "_frame_done"}, {31'd0, done}, 32'd0);
    chk({nm, "_frame_count"}, {16'd0, cnt}, 32'd0);
    chk({nm, "_frame_sum"}, fsum, 32'd0);
    chk_err(nm, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: every FRAME_DONE pulse must match the next queued expectation
  initial begin
    forever begin
      exp_t e;
      @(negedge clk);
      if (rst_n === 1'b1 && done === 1'b1) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_frame_done: got pulse (sum 0x%0h count %0d), want none", fsum, cnt);
        end else begin
          e = q.pop_front();
          chk("frame_sum", fsum, e.sum);
          chk("frame_count", {16'd0, cnt}, {16'd0, e.cnt});
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish, want completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n    = 1'b0;
    tdata    = '0;
    tlast    = 1'b0;
    tuser    = 1'b0;
    tvalid   = 1'b0;
    throttle = 1'b0;
    clear    = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;
    idle(2);
    chk("tready_run", {31'd0, tready}, 32'd1);

    // Two clean frames, continuous ready
    push_exp(32'd112);
    send_frame();
    push_exp(32'd112);
    send_frame();
    idle(3);
    chk("clean_count", {16'd0, cnt}, 32'd2);
    chk_err("clean", 1'b0, 1'b0, 1'b0);

    // Pseudo-random throttle with TVALID held: same checksum, stalls seen
    throttle = 1'b1;
    stalls   = 0;
    push_exp(32'd112);
    send_frame();
    idle(3);
    throttle = 1'b0;
    chk("throttle_stalled", {31'd0, stalls > 0}, 32'd1);
    chk("throttle_count", {16'd0, cnt}, 32'd3);
    chk_err("throttle", 1'b0, 1'b0, 1'b0);

    // Early TLAST on pixel 5 of line 1: 28+15+28+28 = 99
    push_exp(32'd99);
    send_line(H, 1'b1, 1'b0);
    send_line(6, 1'b0, 1'b0);
    send_line(H, 1'b0, 1'b0);
    send_line(H, 1'b0, 1'b0);
    idle(3);
    chk_err("early", 1'b0, 1'b1, 1'b0);
    chk("early_count", {16'd0, cnt}, 32'd4);

    // TUSER on pixel 3 of line 2 aborts; new frame = 3 + (1..7) + 3*28 = 115
    send_line(H, 1'b1, 1'b0);
    send_line(H, 1'b0, 1'b0);
    for (int x = 0; x < 3; x++) beat(DW'(x), 1'b0, 1'b0);
    push_exp(32'd115);
    beat(DW'(3), 1'b1, 1'b0);
    for (int x = 1; x < H; x++) beat(DW'(x), 1'b0, x == H - 1);
    for (int y = 1; y < V; y++) send_line(H, 1'b0, 1'b0);
    idle(3);
    chk_err("sof", 1'b1, 1'b1, 1'b0);
    chk("sof_count", {16'd0, cnt}, 32'd5);

    // Beats before TUSER are discarded from the checksum
    for (int i = 0; i < 5; i++) beat(DW'(100), 1'b0, i == 4);
    push_exp(32'd112);
    send_frame();
    idle(3);
    chk("pre_sof_sum", fsum, 32'd112);
    chk("pre_sof_count", {16'd0, cnt}, 32'd6);

    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    exp_count = 0;
    chk_err("clear", 1'b0, 1'b0, 1'b0);
    chk("clear_count", {16'd0, cnt}, 32'd0);
    chk("clear_keeps_sum", fsum, 32'd112);

    // Missing TLAST at pixel 7 of line 0: late error, frame still completes
    push_exp(32'd112);
    send_line(H, 1'b1, 1'b1);
    for (int y = 1; y < V; y++) send_line(H, 1'b0, 1'b0);
    idle(3);
    chk_err("late", 1'b0, 1'b0, 1'b1);
    chk("late_count", {16'd0, cnt}, 32'd1);

    // Reset mid-frame for 3 cycles, then a full frame counts as 1
    send_line(H, 1'b1, 1'b0);
    beat(DW'(0), 1'b0, 1'b0);
    beat(DW'(1), 1'b0, 1'b0);
    tvalid = 1'b0;
    rst_n  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("midreset");
    rst_n = 1'b1;
    exp_count = 0;
    idle(2);
    push_exp(32'd112);
    send_frame();
    idle(4);
    chk("midreset_count", {16'd0, cnt}, 32'd1);
    chk("midreset_sum", fsum, 32'd112);
    chk_err("midreset_after", 1'b0, 1'b0, 1'b0);
    chk("pending_frames", q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
